mem_lsu: RTL and testbench
==========================

# mem_lsu

MEM-stage load/store unit. Consumes the EX/MEM pipeline register outputs, passes non-memory results straight through, and runs data-memory transactions over a req/ack bus. It holds the pipeline through `stallreq` until each access completes, then presents write-back data to the MEM/WB register. Loads are byte-, halfword- or word-sized with sign or zero extension; stores are byte-, halfword- or word-sized. The bus is big-endian.

## Interface
Parameters: none. Widths come from `defines.v`: `RegBus` 32, `RegAddrBus` 5, `AluOpBus` 8, `InstBus` 32.

Clock and reset are fixed: one clock; reset is synchronous and active-high.

- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  synchronous reset, active-high (`RstEnable` = 1)
- `mem_inst`  in  32  instruction, debug only; passed through
- `mem_waddr`  in  5  destination register
- `mem_reg_we`  in  1  register write enable
- `mem_alu_res`  in  32  ALU result
- `mem_hi_we`, `mem_lo_we`  in  1 each  Hi/Lo write enables
- `mem_hi`, `mem_lo`  in  32 each  Hi/Lo data
- `mem_aluop`  in  8  operation code
- `mem_mem_addr`  in  32  effective byte address
- `mem_reg2_data`  in  32  store source data
- `dmem_req`  out  1  bus request; held until acknowledged
- `dmem_we`  out  1  1 for store, 0 for load
- `dmem_addr`  out  32  word address, `{mem_mem_addr[31:2], 2'b00}`
- `dmem_sel`  out  4  byte enables; bit 3 = byte lane [31:24]
- `dmem_wdata`  out  32  store data, replicated into the selected lanes
- `dmem_rdata`  in  32  read data, valid when `dmem_ack` = 1
- `dmem_ack`  in  1  transaction complete, sampled at the clock edge
- `stallreq`  out  1  stall request to ctrl
- `misalign`  out  1  one-cycle pulse marking a misaligned access
- `wb_waddr`, `wb_reg_we`, `wb_wdata`, `wb_hi_we`, `wb_lo_we`, `wb_hi`, `wb_lo`, `wb_inst`  out  matching widths  to MEM/WB register

## Operation
- Memory operation (`is_mem`): `mem_aluop` is one of `ALU_LB_OP`, `ALU_LBU_OP`, `ALU_LH_OP`, `ALU_LHU_OP`, `ALU_LW_OP`, `ALU_SB_OP`, `ALU_SH_OP`, `ALU_SW_OP`.
- Alignment rules:
  - halfword access needs `addr[0]` = 0
  - word access needs `addr[1:0]` = 0
  - byte access is always aligned
- Non-memory operation: every `wb_*` output is the matching input, combinationally. `stallreq` = 0. No bus activity.
- Misaligned access:
  - no bus transaction, `stallreq` = 0
  - `misalign` = 1 for the cycle
  - `wb_reg_we` = 0 and `wb_hi_we` = `wb_lo_we` = 0
- Byte lanes (big-endian):
  - byte: `sel` is 1000 / 0100 / 0010 / 0001 for `addr[1:0]` = 00 / 01 / 10 / 11
  - halfword: `sel` is 1100 for `addr[1]` = 0, 0011 for `addr[1]` = 1
  - word: `sel` is 1111
- Store data: `wdata` is `{4{reg2[7:0]}}` for bytes and `{2{reg2[15:0]}}` for halfwords.
- Load data:
  - take the selected lane from the captured read word
  - LB/LH sign-extend; LBU/LHU zero-extend
  - write the result to `wb_wdata`
- Store: `wb_reg_we` = 0.

State machine, state register `state`:
- IDLE
  - For an aligned memory operation: `dmem_req` = 1 combinationally and `stallreq` = 1.
  - `ack` = 1 → DONE; capture `rdata` into `ld_buf`.
  - `ack` = 0 → WAIT.
- WAIT
  - `dmem_req` = 1 and `stallreq` = 1.
  - `ack` = 1 → DONE and capture `rdata`; otherwise stay in WAIT.
- DONE
  - `dmem_req` = 0 and `stallreq` = 0.
  - Write-back outputs are valid: loads use `ld_buf`.
  - Always → IDLE next edge. ctrl releases the stall, so EX/MEM loads the next instruction at that same edge. The completed access is never reissued.
- Bus signals `dmem_we`, `addr`, `sel`, `wdata` are stable for the whole time `req` = 1.

## Timing
- Reset (`rst` = 1 at an edge):
  - `state` → IDLE, `ld_buf` → 0
  - while `rst` = 1, all outputs are 0: `wb_waddr` = `NOPRegAddr`, `dmem_req` = `stallreq` = `misalign` = 0
- Reset during WAIT: the request drops after the edge, with no DONE cycle. The bus slave must tolerate an abandoned request.
- Non-memory operations and misaligned accesses: 0 cycles of added latency.
- Aligned access:
  - the operation enters MEM in cycle 0
  - `ack` arrives at the end of cycle k, with k ≥ 0
  - DONE is cycle k+1, with write-back valid
  - the stall lasts k+1 cycles
  - minimum extra latency is 1 cycle
- `dmem_ack` outside IDLE/WAIT with `req` = 1 is ignored.
- `dmem_rdata` is read only at the `ack` edge. It does not need to stay valid afterwards.

## Structure
- `defines.v` holds:
  - the eight load/store `AluOp` codes
  - the state encodings `LSU_IDLE`, `LSU_WAIT`, `LSU_DONE` (2 bits)
  - `NOPRegAddr` and `ZeroWord`
- One combinational sub-module, `lsu_align`, covers both directions. Store side: (aluop, addr[1:0], reg2) → (sel, wdata). Load side: (aluop, addr[1:0], word) → extended load result.

## Test plan
- ADD result 0x0000_1234 to $5 → `wb_wdata` = 0x1234, `wb_waddr` = 5, `stallreq` = 0, `dmem_req` stays 0.
- LB at 0x103, `ack` in the same cycle, `rdata` = 0x1122_3380 → `sel` = 0001, 1 stall cycle, `wb_wdata` = 0xFFFF_FF80. LBU on the same inputs → 0x0000_0080.
- LH at 0x102, `ack` delayed 3 cycles, `rdata` = 0xAAAA_8001 → `stallreq` high for 4 cycles, `sel` = 0011, `wb_wdata` = 0xFFFF_8001.
- SB at 0x201 with `reg2` = 0x0000_00EE → `dmem_we` = 1, `sel` = 0100, `wdata` = 0xEEEE_EEEE, `wb_reg_we` = 0.
- LW at 0x302 → `misalign` = 1, `dmem_req` = 0, `wb_reg_we` = 0, no stall.
- `rst` asserted in WAIT → next cycle: `dmem_req` = 0, `stallreq` = 0, `state` = IDLE. A following SW to 0x400 completes normally with `sel` = 1111.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared opcodes, FSM states and access decoding for the MEM-stage load/store unit.
package mem_lsu_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int ALUOP_BUS    = 8;
    localparam int INST_BUS     = 32;

    localparam logic [ALUOP_BUS-1:0] ALU_LB_OP  = 8'b1110_0000;
    localparam logic [ALUOP_BUS-1:0] ALU_LH_OP  = 8'b1110_0001;
    localparam logic [ALUOP_BUS-1:0] ALU_LW_OP  = 8'b1110_0011;
    localparam logic [ALUOP_BUS-1:0] ALU_LBU_OP = 8'b1110_0100;
    localparam logic [ALUOP_BUS-1:0] ALU_LHU_OP = 8'b1110_0101;
    localparam logic [ALUOP_BUS-1:0] ALU_SB_OP  = 8'b1110_1000;
    localparam logic [ALUOP_BUS-1:0] ALU_SH_OP  = 8'b1110_1001;
    localparam logic [ALUOP_BUS-1:0] ALU_SW_OP  = 8'b1110_1011;

    localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = 5'd0;
    localparam logic [REG_BUS-1:0]      ZERO_WORD    = 32'd0;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_WAIT = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } acc_size_e;

    function automatic logic is_load_op(input logic [ALUOP_BUS-1:0] op);
        return (op == ALU_LB_OP) || (op == ALU_LBU_OP) || (op == ALU_LH_OP) ||
               (op == ALU_LHU_OP) || (op == ALU_LW_OP);
    endfunction

    function automatic logic is_mem_op(input logic [ALUOP_BUS-1:0] op);
        return is_load_op(op) || (op == ALU_SB_OP) || (op == ALU_SH_OP) || (op == ALU_SW_OP);
    endfunction

    // Non-memory opcodes decode as word size; callers qualify with is_mem_op.
    function automatic acc_size_e op_size(input logic [ALUOP_BUS-1:0] op);
        case (op)
            ALU_LB_OP, ALU_LBU_OP, ALU_SB_OP: return SZ_BYTE;
            ALU_LH_OP, ALU_LHU_OP, ALU_SH_OP: return SZ_HALF;
            default:                          return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [ALUOP_BUS-1:0] op, input logic [1:0] lo);
        case (op_size(op))
            SZ_HALF: return !lo[0];
            SZ_WORD: return lo == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Big-endian lane steering: store byte enables/data and load extraction/extension.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [ALUOP_BUS-1:0] aluop_i,
    input  logic [1:0]           addr_lo_i,
    input  logic [REG_BUS-1:0]   reg2_i,
    input  logic [REG_BUS-1:0]   rword_i,
    output logic [3:0]           sel_o,
    output logic [REG_BUS-1:0]   wdata_o,
    output logic [REG_BUS-1:0]   ldata_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Store side: lane 0 (addr 00) is the most significant byte of the bus word.
    always_comb begin
        sel_o   = 4'b1111;
        wdata_o = reg2_i;
        case (op_size(aluop_i))
            SZ_BYTE: begin
                sel_o   = 4'b1000 >> addr_lo_i;
                wdata_o = {4{reg2_i[7:0]}};
            end
            SZ_HALF: begin
                sel_o   = addr_lo_i[1] ? 4'b0011 : 4'b1100;
                wdata_o = {2{reg2_i[15:0]}};
            end
            default: begin
                sel_o   = 4'b1111;
                wdata_o = reg2_i;
            end
        endcase
    end

    // Load side: pick the addressed lane from the captured word, then extend.
    always_comb begin
        case (addr_lo_i)
            2'b00:   byte_lane = rword_i[31:24];
            2'b01:   byte_lane = rword_i[23:16];
            2'b10:   byte_lane = rword_i[15:8];
            default: byte_lane = rword_i[7:0];
        endcase
        half_lane = addr_lo_i[1] ? rword_i[15:0] : rword_i[31:16];
        case (aluop_i)
            ALU_LB_OP:  ldata_o = {{24{byte_lane[7]}}, byte_lane};
            ALU_LBU_OP: ldata_o = {24'd0, byte_lane};
            ALU_LH_OP:  ldata_o = {{16{half_lane[15]}}, half_lane};
            ALU_LHU_OP: ldata_o = {16'd0, half_lane};
            default:    ldata_o = rword_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: pass-through for ALU results, req/ack bus for memory ops.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INST_BUS-1:0]     mem_inst,
    input  logic [REG_ADDR_BUS-1:0] mem_waddr,
    input  logic                    mem_reg_we,
    input  logic [REG_BUS-1:0]      mem_alu_res,
    input  logic                    mem_hi_we,
    input  logic                    mem_lo_we,
    input  logic [REG_BUS-1:0]      mem_hi,
    input  logic [REG_BUS-1:0]      mem_lo,
    input  logic [ALUOP_BUS-1:0]    mem_aluop,
    input  logic [REG_BUS-1:0]      mem_mem_addr,
    input  logic [REG_BUS-1:0]      mem_reg2_data,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [REG_BUS-1:0]      dmem_addr,
    output logic [3:0]              dmem_sel,
    output logic [REG_BUS-1:0]      dmem_wdata,
    input  logic [REG_BUS-1:0]      dmem_rdata,
    input  logic                    dmem_ack,
    output logic                    stallreq,
    output logic                    misalign,
    output logic [REG_ADDR_BUS-1:0] wb_waddr,
    output logic                    wb_reg_we,
    output logic [REG_BUS-1:0]      wb_wdata,
    output logic                    wb_hi_we,
    output logic                    wb_lo_we,
    output logic [REG_BUS-1:0]      wb_hi,
    output logic [REG_BUS-1:0]      wb_lo,
    output logic [INST_BUS-1:0]     wb_inst
);

    lsu_state_e         state_q, state_d;
    logic [REG_BUS-1:0] ld_buf_q, ld_buf_d;
    logic               is_mem, is_load, aligned, access, req;
    logic [3:0]         lane_sel;
    logic [REG_BUS-1:0] st_wdata, ld_data;

    assign is_mem  = is_mem_op(mem_aluop);
    assign is_load = is_load_op(mem_aluop);
    assign aligned = is_aligned(mem_aluop, mem_mem_addr[1:0]);
    assign access  = is_mem && aligned;

    lsu_align u_align (
        .aluop_i   (mem_aluop),
        .addr_lo_i (mem_mem_addr[1:0]),
        .reg2_i    (mem_reg2_data),
        .rword_i   (ld_buf_q),
        .sel_o     (lane_sel),
        .wdata_o   (st_wdata),
        .ldata_o   (ld_data)
    );

    // Next state: issue on an aligned access, hold until ack, then one DONE cycle.
    always_comb begin
        state_d  = state_q;
        ld_buf_d = ld_buf_q;
        req      = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (access) begin
                    req = 1'b1;
                    if (dmem_ack) begin
                        state_d  = LSU_DONE;
                        ld_buf_d = dmem_rdata;
                    end else begin
                        state_d = LSU_WAIT;
                    end
                end
            end
            LSU_WAIT: begin
                req = 1'b1;
                if (dmem_ack) begin
                    state_d  = LSU_DONE;
                    ld_buf_d = dmem_rdata;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // State register and captured read word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LSU_IDLE;
            ld_buf_q <= ZERO_WORD;
        end else begin
            state_q  <= state_d;
            ld_buf_q <= ld_buf_d;
        end
    end

    // Outputs: everything forced low during reset; bus fields only driven while requesting.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = ZERO_WORD;
        dmem_sel   = 4'b0000;
        dmem_wdata = ZERO_WORD;
        stallreq   = 1'b0;
        misalign   = 1'b0;
        wb_waddr   = NOP_REG_ADDR;
        wb_reg_we  = 1'b0;
        wb_wdata   = ZERO_WORD;
        wb_hi_we   = 1'b0;
        wb_lo_we   = 1'b0;
        wb_hi      = ZERO_WORD;
        wb_lo      = ZERO_WORD;
        wb_inst    = ZERO_WORD;
        if (!rst) begin
            dmem_req = req;
            stallreq = req;
            if (req) begin
                dmem_we    = !is_load;
                dmem_addr  = {mem_mem_addr[31:2], 2'b00};
                dmem_sel   = lane_sel;
                dmem_wdata = is_load ? ZERO_WORD : st_wdata;
            end
            misalign  = (state_q == LSU_IDLE) && is_mem && !aligned;
            wb_inst   = mem_inst;
            wb_waddr  = mem_waddr;
            wb_hi     = mem_hi;
            wb_lo     = mem_lo;
            wb_hi_we  = mem_hi_we;
            wb_lo_we  = mem_lo_we;
            wb_reg_we = mem_reg_we;
            wb_wdata  = mem_alu_res;
            if (is_mem) begin
                // Only a completed load writes a register; stores and misaligned ops never do.
                wb_reg_we = is_load && mem_reg_we && (state_q == LSU_DONE);
                if (is_load && (state_q == LSU_DONE)) begin
                    wb_wdata = ld_data;
                end
            end
            if (req || misalign) begin
                wb_hi_we = 1'b0;
                wb_lo_we = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: driver emulates ctrl and the bus slave, monitor checks outputs.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam logic [7:0] OP_ADD = 8'b0010_0000;
    localparam logic [7:0] OP_OR  = 8'b0010_0101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_inst = '0, mem_alu_res = '0, mem_hi = '0, mem_lo = '0;
    logic [31:0] mem_mem_addr = '0, mem_reg2_data = '0, dmem_rdata = '0;
    logic [4:0]  mem_waddr = '0;
    logic        mem_reg_we = 1'b0, mem_hi_we = 1'b0, mem_lo_we = 1'b0, dmem_ack = 1'b0;
    logic [7:0]  mem_aluop = '0;
    logic        dmem_req, dmem_we, stallreq, misalign, wb_reg_we, wb_hi_we, wb_lo_we;
    logic [31:0] dmem_addr, dmem_wdata, wb_wdata, wb_hi, wb_lo, wb_inst;
    logic [3:0]  dmem_sel;
    logic [4:0]  wb_waddr;

    mem_lsu dut (
        .clk(clk), .rst(rst), .mem_inst(mem_inst), .mem_waddr(mem_waddr),
        .mem_reg_we(mem_reg_we), .mem_alu_res(mem_alu_res), .mem_hi_we(mem_hi_we),
        .mem_lo_we(mem_lo_we), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_reg2_data(mem_reg2_data), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_sel(dmem_sel), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stallreq(stallreq), .misalign(misalign),
        .wb_waddr(wb_waddr), .wb_reg_we(wb_reg_we), .wb_wdata(wb_wdata), .wb_hi_we(wb_hi_we),
        .wb_lo_we(wb_lo_we), .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_inst(wb_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr, reg2, rdata, alu, hi, lo, inst;
        logic [4:0]  waddr;
        logic        reg_we, hi_we, lo_we;
        int          k;
    } stim_t;

    typedef struct {
        logic        misal, we;
        logic [3:0]  sel;
        logic [31:0] baddr, bwdata, wdata, hi, lo, inst;
        logic [4:0]  waddr;
        logic        reg_we, hi_we, lo_we;
        int          stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   stall_cnt = 0;
    bit   running = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Architectural view of an opcode: memory or not, load or store, signedness, byte count.
    function automatic void op_info(input logic [7:0] op, output bit mem, output bit ld,
                                    output bit sgn, output int size);
        mem = 1; ld = 0; sgn = 0; size = 4;
        case (op)
            ALU_LB_OP:  begin ld = 1; sgn = 1; size = 1; end
            ALU_LBU_OP: begin ld = 1; size = 1; end
            ALU_LH_OP:  begin ld = 1; sgn = 1; size = 2; end
            ALU_LHU_OP: begin ld = 1; size = 2; end
            ALU_LW_OP:  ld = 1;
            ALU_SB_OP:  size = 1;
            ALU_SH_OP:  size = 2;
            ALU_SW_OP:  size = 4;
            default:    mem = 0;
        endcase
    endfunction

    // Reference model: bytes numbered 0..3 from the MSB of the bus word (big-endian).
    function automatic exp_t model(input stim_t s);
        exp_t   e;
        bit     mem, ld, sgn;
        int     size, off, idx;
        longint val;
        op_info(s.op, mem, ld, sgn, size);
        off = int'(s.addr[1:0]);
        e.misal  = mem && (off % size != 0);
        e.inst   = s.inst;  e.waddr = s.waddr;
        e.hi     = s.hi;    e.lo    = s.lo;
        e.hi_we  = s.hi_we; e.lo_we = s.lo_we;
        e.reg_we = s.reg_we;
        e.wdata  = s.alu;
        e.stall  = 0;
        e.we     = !ld;
        e.baddr  = s.addr - 32'(off);
        e.sel    = '0;
        e.bwdata = '0;
        if (mem && e.misal) begin
            e.reg_we = 0; e.hi_we = 0; e.lo_we = 0;
        end else if (mem) begin
            e.stall = s.k + 1;
            for (int i = 0; i < 4; i++) begin
                e.sel[3-i] = (i >= off) && (i < off + size);
                idx = size - 1 - (i % size);
                e.bwdata[31-8*i -: 8] = s.reg2[8*idx +: 8];
            end
            if (ld) begin
                val = 0;
                for (int b = 0; b < size; b++)
                    val = val * 256 + longint'(s.rdata[31-8*(off+b) -: 8]);
                if (sgn && size < 4 && ((val >> (8*size-1)) & 1) == 1)
                    val = val - (longint'(1) << (8*size));
                e.wdata = val[31:0];
            end else begin
                e.reg_we = 0;
            end
        end
        return e;
    endfunction

    function automatic stim_t mk(input logic [7:0] op, input logic [31:0] addr,
                                 input logic [31:0] reg2, input logic [31:0] rdata,
                                 input logic [31:0] alu, input logic [4:0] waddr, input int k);
        stim_t s;
        s.op = op; s.addr = addr; s.reg2 = reg2; s.rdata = rdata; s.alu = alu;
        s.waddr = waddr; s.k = k; s.reg_we = 1'b1;
        s.inst = $urandom; s.hi = $urandom; s.lo = $urandom;
        s.hi_we = 1'($urandom_range(0, 1));
        s.lo_we = 1'($urandom_range(0, 1));
        return s;
    endfunction

    // Present one instruction, act as bus slave, and advance only when stallreq is low.
    task automatic run(input stim_t s, input int abort_at);
        exp_t e;
        bit   st;
        bit   access;
        int   j;
        e = model(s);
        access = (e.stall > 0);
        exp_q.push_back(e);
        mem_inst = s.inst; mem_waddr = s.waddr; mem_reg_we = s.reg_we;
        mem_alu_res = s.alu; mem_hi_we = s.hi_we; mem_lo_we = s.lo_we;
        mem_hi = s.hi; mem_lo = s.lo; mem_aluop = s.op;
        mem_mem_addr = s.addr; mem_reg2_data = s.reg2;
        j = 0;
        forever begin
            if (j == abort_at) begin
                rst = 1'b1; dmem_ack = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if (access && j <= s.k) dmem_ack = (j == s.k);
            else                    dmem_ack = 1'($urandom_range(0, 1));
            dmem_rdata = (access && j == s.k) ? s.rdata : $urandom;
            @(negedge clk);
            st = stallreq;
            @(posedge clk); #1;
            if (!st) return;
            j++;
            if (j > s.k + 8) begin
                n_cmp++; n_fail++;
                $display("FAIL timeout: stallreq still high after %0d cycles, required %0d", j, e.stall);
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
        end
    endtask

    // Monitor: reset gating, bus fields while stalled, write-back on the release cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("reset_outputs_zero",
                32'(|{dmem_req, dmem_we, dmem_addr, dmem_sel, dmem_wdata, stallreq, misalign,
                      wb_waddr, wb_reg_we, wb_wdata, wb_hi_we, wb_lo_we, wb_hi, wb_lo, wb_inst}),
                32'd0);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            stall_cnt = 0;
        end else if (running) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output_cycle", 32'(exp_q.size()), 32'd1);
            end else if (stallreq) begin
                e = exp_q[0];
                stall_cnt++;
                chk("req_while_stall", 32'(dmem_req), 32'd1);
                chk("misalign_while_stall", 32'(misalign), 32'd0);
                chk("bus_we", 32'(dmem_we), 32'(e.we));
                chk("bus_addr", dmem_addr, e.baddr);
                chk("bus_sel", 32'(dmem_sel), 32'(e.sel));
                if (e.we) chk("bus_wdata", dmem_wdata, e.bwdata);
            end else begin
                e = exp_q.pop_front();
                chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                chk("req_idle", 32'(dmem_req), 32'd0);
                chk("misalign", 32'(misalign), 32'(e.misal));
                chk("wb_reg_we", 32'(wb_reg_we), 32'(e.reg_we));
                chk("wb_waddr", 32'(wb_waddr), 32'(e.waddr));
                chk("wb_wdata", wb_wdata, e.wdata);
                chk("wb_inst", wb_inst, e.inst);
                chk("wb_hi_we", 32'(wb_hi_we), 32'(e.hi_we));
                chk("wb_lo_we", 32'(wb_lo_we), 32'(e.lo_we));
                chk("wb_hi", wb_hi, e.hi);
                chk("wb_lo", wb_lo, e.lo);
                stall_cnt = 0;
            end
        end
    end

    function automatic logic [7:0] pick_op(input int n);
        case (n)
            0: return ALU_LB_OP;  1: return ALU_LBU_OP; 2: return ALU_LH_OP;
            3: return ALU_LHU_OP; 4: return ALU_LW_OP;  5: return ALU_SB_OP;
            6: return ALU_SH_OP;  7: return ALU_SW_OP;  8: return OP_ADD;
            default: return OP_OR;
        endcase
    endfunction

    initial begin
        stim_t       s;
        logic [7:0]  op;
        logic [31:0] a;
        // Reset with an aligned load and ack presented: outputs must stay gated low.
        mem_aluop = ALU_LW_OP; mem_mem_addr = 32'h0000_0100; mem_reg_we = 1'b1;
        mem_alu_res = 32'hDEAD_BEEF; mem_inst = 32'h1234_5678; mem_waddr = 5'd7;
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        running = 1'b1;

        run(mk(OP_ADD, 32'h0, 32'h0, 32'h0, 32'h0000_1234, 5'd5, 0), -1);
        run(mk(ALU_LB_OP, 32'h103, 32'h0, 32'h1122_3380, 32'h0, 5'd6, 0), -1);
        run(mk(ALU_LBU_OP, 32'h103, 32'h0, 32'h1122_3380, 32'h0, 5'd6, 0), -1);
        run(mk(ALU_LH_OP, 32'h102, 32'h0, 32'hAAAA_8001, 32'h0, 5'd8, 3), -1);
        run(mk(ALU_SB_OP, 32'h201, 32'h0000_00EE, 32'h0, 32'h0, 5'd9, 1), -1);
        run(mk(ALU_LW_OP, 32'h302, 32'h0, 32'h0, 32'h0000_0302, 5'd10, 0), -1);
        run(mk(ALU_LH_OP, 32'h500, 32'h0, 32'h5555_6666, 32'h0, 5'd11, 6), 3);
        run(mk(ALU_SW_OP, 32'h400, 32'h89AB_CDEF, 32'h0, 32'h0, 5'd12, 2), -1);

        for (int t = 0; t < 400; t++) begin
            op = pick_op($urandom_range(0, 9));
            a = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (op == ALU_LH_OP || op == ALU_LHU_OP || op == ALU_SH_OP) a[0] = 1'b0;
                if (op == ALU_LW_OP || op == ALU_SW_OP) a[1:0] = 2'b00;
            end
            s = mk(op, a, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 4));
            run(s, -1);
        end

        running = 1'b0;
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, required completion before 1ms");
        $fatal(1, "time limit");
    end

endmodule
